// File: rtl/apb_uart_regs.sv
// APB completer for the UART register map: TX/RX byte FIFOs, control, baud divisor,
// sticky RX overrun flag and level interrupt. Every access takes exactly one wait state.
module apb_uart_regs #(
    parameter int          WIDTH      = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_psel,
    input  logic             i_penable,
    input  logic             i_pwrite,
    input  logic [31:0]      i_paddr,
    input  logic [WIDTH-1:0] i_pwdata,
    output logic [WIDTH-1:0] o_prdata,
    output logic             o_pready,
    output logic             o_pslverr,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [15:0]      o_baud_div,
    output logic             o_irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_prdata;
    logic             r_pslverr;
    logic [2:0]       r_ctrl;
    logic [15:0]      r_baud_div;
    logic             r_rx_overrun;

    logic [7:0]       r_tx_mem [FIFO_DEPTH];
    logic [7:0]       r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [CW-1:0]    r_tx_count, r_rx_count;

    logic             w_access, w_aligned;
    logic [2:0]       w_offset;
    logic             w_sel_tx, w_sel_rx, w_sel_status, w_sel_ctrl, w_sel_baud;
    logic             w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic             w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_ovr_clr;
    logic [23:0]      w_status;
    logic [WIDTH-1:0] w_rdata;
    logic             w_err;
    logic             w_unused;

    assign w_access     = (r_state == ST_IDLE) & i_psel & i_penable;
    assign w_aligned    = (i_paddr[1:0] == 2'b00);
    assign w_offset     = i_paddr[4:2];
    assign w_sel_tx     = w_access & w_aligned & (w_offset == 3'd0);
    assign w_sel_rx     = w_access & w_aligned & (w_offset == 3'd1);
    assign w_sel_status = w_access & w_aligned & (w_offset == 3'd2);
    assign w_sel_ctrl   = w_access & w_aligned & (w_offset == 3'd3);
    assign w_sel_baud   = w_access & w_aligned & (w_offset == 3'd4);

    assign w_tx_full  = (r_tx_count == CW'(FIFO_DEPTH));
    assign w_tx_empty = (r_tx_count == '0);
    assign w_rx_full  = (r_rx_count == CW'(FIFO_DEPTH));
    assign w_rx_empty = (r_rx_count == '0);

    // Full/empty come from start-of-cycle occupancy, so a same-edge pop never rescues a push.
    assign w_tx_push = w_sel_tx & i_pwrite & ~w_tx_full;
    assign w_tx_pop  = o_tx_valid & i_tx_ready;
    assign w_rx_push = i_rx_valid & ~w_rx_full;
    assign w_rx_pop  = w_sel_rx & ~i_pwrite & ~w_rx_empty;
    assign w_ovr_clr = w_sel_status & i_pwrite & i_pwdata[4];

    assign w_status = {8'(r_rx_count), 8'(r_tx_count), 3'b000, r_rx_overrun,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    assign w_unused = ^{i_paddr[31:5], i_pwdata[WIDTH-1:16]};

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (!w_aligned) begin
            w_err = 1'b1;
        end else begin
            case (w_offset)
                3'd0: w_err = i_pwrite & w_tx_full;
                3'd1: begin
                    if (!i_pwrite) begin
                        w_err   = w_rx_empty;
                        w_rdata = w_rx_empty ? '0 : WIDTH'(r_rx_mem[r_rx_rptr]);
                    end
                end
                3'd2: if (!i_pwrite) w_rdata = WIDTH'(w_status);
                3'd3: if (!i_pwrite) w_rdata = WIDTH'(r_ctrl);
                3'd4: if (!i_pwrite) w_rdata = WIDTH'(r_baud_div);
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_state   <= ST_RESP;
                        r_prdata  <= w_rdata;
                        r_pslverr <= w_err;
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_HOLD;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                end
                ST_HOLD: begin
                    if (!i_psel || !i_penable) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl       <= '0;
            r_baud_div   <= DIV_RESET;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_sel_ctrl && i_pwrite) r_ctrl <= i_pwdata[2:0];
            if (w_sel_baud && i_pwrite) r_baud_div <= i_pwdata[15:0];
            // A new overrun on the same edge as a clear must survive.
            if (i_rx_valid && w_rx_full) r_rx_overrun <= 1'b1;
            else if (w_ovr_clr)          r_rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + PW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
            r_tx_count <= r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PW'(1);
            r_rx_count <= r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= i_pwdata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_rx_data;
    end

    assign o_prdata   = r_prdata;
    assign o_pready   = (r_state == ST_RESP);
    assign o_pslverr  = r_pslverr;
    assign o_tx_valid = r_ctrl[0] & ~w_tx_empty;
    assign o_tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
    assign o_baud_div = r_baud_div;
    assign o_irq      = (r_ctrl[1] & ~w_rx_empty) | (r_ctrl[2] & w_tx_empty);

endmodule

// File: tb/tb_apb_uart_regs.sv
// Self-checking bench for apb_uart_regs: APB responses are scored against a queue of
// expectations derived from a small FIFO/register model; TX drain is scored by a monitor.
module tb_apb_uart_regs;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
        logic        hold;
    } opT;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [7:0]  txData;
    logic        txValid, txReady;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [15:0] baudDiv;
    logic        irq;

    int          vectorsApplied = 0;
    int          miscompares = 0;
    int          cycle = 0;

    expT         expQ[$];
    logic [7:0]  txExp[$];
    logic [7:0]  txObs[$];
    int          txObsCyc[$];
    logic [7:0]  rxModel[$];
    bit          rxOvr = 1'b0;

    apb_uart_regs #(.WIDTH(32), .FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
        .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata), .o_pready(pready),
        .o_pslverr(pslverr), .o_tx_data(txData), .o_tx_valid(txValid), .i_tx_ready(txReady),
        .i_rx_data(rxData), .i_rx_valid(rxValid), .o_baud_div(baudDiv), .o_irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (txValid && txReady) begin
            txObs.push_back(txData);
            txObsCyc.push_back(cycle);
        end
    end

    function automatic opT mkOp(logic [31:0] a, logic w, logic [31:0] d,
                                logic [31:0] ed, logic ee, logic h = 1'b0);
        opT o;
        o.addr = a; o.wr = w; o.wdata = d; o.expData = ed; o.expErr = ee; o.hold = h;
        return o;
    endfunction

    function automatic expT mkExp(logic [31:0] d, logic e);
        expT x;
        x.data = d; x.err = e;
        return x;
    endfunction

    function automatic logic [31:0] statusWord(int txCnt, int rxCnt, bit ovr);
        return {8'h00, 8'(rxCnt), 8'(txCnt), 3'b000, ovr,
                rxCnt == 0, rxCnt == 8, txCnt == 0, txCnt == 8};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one APB transfer starting now (just after an edge); returns the response and
    // how many edges after the first access cycle pready appeared (0 on timeout).
    task automatic apb_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                              input logic hold, output logic [31:0] rdata, output logic err,
                              output int lat);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; rdata = 'x; err = 1'bx;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (pready) begin
                lat = c; rdata = prdata; err = pslverr;
                break;
            end
        end
        @(posedge clk); #1;
        if (hold) begin
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rxData = b; rxValid = 1'b1;
        if (rxModel.size() < 8) rxModel.push_back(b);
        else rxOvr = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
    endtask

    task automatic test_reset;
        opT ops[$]; expT e; logic [31:0] rd; logic er; int lat;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        vectorsApplied++;
        if ({prdata, pready, pslverr, txValid, txData, irq, baudDiv} !==
            {32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd868}) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: prdata=%h pready=%b pslverr=%b txv=%b txd=%h irq=%b baud=%0d, want 0/0/0/0/0/0/868",
                     prdata, pready, pslverr, txValid, txData, irq, baudDiv);
        end
        rst = 1'b0;
        idle(1);
        ops.push_back(mkOp(32'h08, 1'b0, 0, 32'h0000000A, 1'b0));
        ops.push_back(mkOp(32'h10, 1'b0, 0, 32'h00000364, 1'b0));
        foreach (ops[k]) begin
            expQ.push_back(mkExp(ops[k].expData, ops[k].expErr));
            apb_access(ops[k].addr, ops[k].wr, ops[k].wdata, ops[k].hold, rd, er, lat);
            e = expQ.pop_front();
            vectorsApplied++;
            if (rd !== e.data || er !== e.err || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL reset_read[%0d] @%h: got %h/%b lat %0d, want %h/%b lat 1",
                         k, ops[k].addr, rd, er, lat, e.data, e.err);
            end
        end
    endtask

    task automatic test_baud_div;
        opT ops[$]; expT e; logic [31:0] rd; logic er; int lat;
        ops.push_back(mkOp(32'h10, 1'b1, 32'h10, 0, 1'b0));
        ops.push_back(mkOp(32'h10, 1'b0, 0, 32'h10, 1'b0));
        ops.push_back(mkOp(32'h14, 1'b1, 32'hFF, 0, 1'b1));
        ops.push_back(mkOp(32'h11, 1'b1, 32'h55, 0, 1'b1));
        ops.push_back(mkOp(32'h0E, 1'b0, 0, 0, 1'b1));
        ops.push_back(mkOp(32'h0C, 1'b0, 0, 0, 1'b0));
        ops.push_back(mkOp(32'h30, 1'b0, 0, 32'h10, 1'b0));
        foreach (ops[k]) begin
            expQ.push_back(mkExp(ops[k].expData, ops[k].expErr));
            apb_access(ops[k].addr, ops[k].wr, ops[k].wdata, ops[k].hold, rd, er, lat);
            e = expQ.pop_front();
            vectorsApplied++;
            if (rd !== e.data || er !== e.err || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL baud_op[%0d] @%h: got %h/%b lat %0d, want %h/%b lat 1",
                         k, ops[k].addr, rd, er, lat, e.data, e.err);
            end
        end
        vectorsApplied++;
        if (baudDiv !== 16'd16) begin
            miscompares++;
            $display("[TB] FAIL baud_div_port: got %0d, want 16", baudDiv);
        end
    endtask

    task automatic test_tx_fill_drain;
        opT ops[$]; expT e; logic [31:0] rd; logic er; int lat; int txCnt;
        txCnt = 0;
        txReady = 1'b1;
        ops.push_back(mkOp(32'h0C, 1'b1, 32'h0, 0, 1'b0));
        for (int i = 0; i < 9; i++) begin
            if (txCnt < 8) begin
                txExp.push_back(8'(8'h41 + i));
                ops.push_back(mkOp(32'h00, 1'b1, 32'h41 + i, 0, 1'b0));
                txCnt++;
            end else begin
                ops.push_back(mkOp(32'h00, 1'b1, 32'h41 + i, 0, 1'b1));
            end
        end
        ops.push_back(mkOp(32'h08, 1'b0, 0, statusWord(txCnt, 0, 1'b0), 1'b0));
        ops.push_back(mkOp(32'h00, 1'b0, 0, 0, 1'b0));
        ops.push_back(mkOp(32'h0C, 1'b1, 32'h1, 0, 1'b0));
        txObs.delete(); txObsCyc.delete();
        foreach (ops[k]) begin
            expQ.push_back(mkExp(ops[k].expData, ops[k].expErr));
            apb_access(ops[k].addr, ops[k].wr, ops[k].wdata, ops[k].hold, rd, er, lat);
            e = expQ.pop_front();
            vectorsApplied++;
            if (rd !== e.data || er !== e.err || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL tx_op[%0d] @%h: got %h/%b lat %0d, want %h/%b lat 1",
                         k, ops[k].addr, rd, er, lat, e.data, e.err);
            end
        end
        idle(12);
        txReady = 1'b0;
        vectorsApplied++;
        if (txObs.size() != 8) begin
            miscompares++;
            $display("[TB] FAIL tx_drain_count: got %0d bytes, want 8", txObs.size());
        end
        for (int k = 0; k < 8 && k < txObs.size(); k++) begin
            logic [7:0] want;
            want = txExp.pop_front();
            vectorsApplied++;
            if (txObs[k] !== want || txObsCyc[k] != txObsCyc[0] + k) begin
                miscompares++;
                $display("[TB] FAIL tx_drain[%0d]: got %h at +%0d cycles, want %h at +%0d",
                         k, txObs[k], txObsCyc[k] - txObsCyc[0], want, k);
            end
        end
        ops.delete();
        ops.push_back(mkOp(32'h08, 1'b0, 0, statusWord(0, 0, 1'b0), 1'b0));
        ops.push_back(mkOp(32'h0C, 1'b1, 32'h4, 0, 1'b0));
        foreach (ops[k]) begin
            expQ.push_back(mkExp(ops[k].expData, ops[k].expErr));
            apb_access(ops[k].addr, ops[k].wr, ops[k].wdata, ops[k].hold, rd, er, lat);
            e = expQ.pop_front();
            vectorsApplied++;
            if (rd !== e.data || er !== e.err || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL tx_post[%0d] @%h: got %h/%b lat %0d, want %h/%b lat 1",
                         k, ops[k].addr, rd, er, lat, e.data, e.err);
            end
        end
        vectorsApplied++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tx_irq: got %b, want 1", irq);
        end
    endtask

    task automatic test_rx_fill_overrun;
        opT ops[$]; expT e; logic [31:0] rd; logic er; int lat;
        expQ.push_back(mkExp(0, 1'b0));
        apb_access(32'h0C, 1'b1, 32'h2, 1'b0, rd, er, lat);
        e = expQ.pop_front();
        vectorsApplied++;
        if (rd !== e.data || er !== e.err || lat != 1 || irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rx_ctrl_wr: got %h/%b lat %0d irq %b, want %h/%b lat 1 irq 0",
                     rd, er, lat, irq, e.data, e.err);
        end
        for (int i = 0; i < 9; i++) pulse_rx(8'(8'h10 + i));
        vectorsApplied++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rx_irq: got %b, want 1", irq);
        end
        ops.push_back(mkOp(32'h08, 1'b0, 0, statusWord(0, rxModel.size(), rxOvr), 1'b0));
        for (int i = 0; i < 9; i++) begin
            if (rxModel.size() > 0) ops.push_back(mkOp(32'h04, 1'b0, 0, 32'(rxModel.pop_front()), 1'b0));
            else                    ops.push_back(mkOp(32'h04, 1'b0, 0, 0, 1'b1));
        end
        ops.push_back(mkOp(32'h04, 1'b1, 32'hAB, 0, 1'b0));
        ops.push_back(mkOp(32'h08, 1'b1, 32'hFFFF_FFEF, 0, 1'b0));
        ops.push_back(mkOp(32'h08, 1'b0, 0, statusWord(0, 0, rxOvr), 1'b0));
        rxOvr = 1'b0;
        ops.push_back(mkOp(32'h08, 1'b1, 32'h10, 0, 1'b0));
        ops.push_back(mkOp(32'h08, 1'b0, 0, statusWord(0, 0, rxOvr), 1'b0));
        foreach (ops[k]) begin
            expQ.push_back(mkExp(ops[k].expData, ops[k].expErr));
            apb_access(ops[k].addr, ops[k].wr, ops[k].wdata, ops[k].hold, rd, er, lat);
            e = expQ.pop_front();
            vectorsApplied++;
            if (rd !== e.data || er !== e.err || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL rx_op[%0d] @%h: got %h/%b lat %0d, want %h/%b lat 1",
                         k, ops[k].addr, rd, er, lat, e.data, e.err);
            end
        end
        vectorsApplied++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rx_irq_empty: got %b, want 0", irq);
        end
    endtask

    task automatic test_hold;
        opT ops[$]; expT e; logic [31:0] rd; logic er; int lat;
        ops.push_back(mkOp(32'h00, 1'b1, 32'h77, 0, 1'b0, 1'b1));
        ops.push_back(mkOp(32'h08, 1'b0, 0, statusWord(1, 0, 1'b0), 1'b0));
        foreach (ops[k]) begin
            expQ.push_back(mkExp(ops[k].expData, ops[k].expErr));
            apb_access(ops[k].addr, ops[k].wr, ops[k].wdata, ops[k].hold, rd, er, lat);
            e = expQ.pop_front();
            vectorsApplied++;
            if (rd !== e.data || er !== e.err || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL hold_op[%0d] @%h: got %h/%b lat %0d, want %h/%b lat 1",
                         k, ops[k].addr, rd, er, lat, e.data, e.err);
            end
        end
    endtask

    task automatic test_back_to_back;
        opT ops[$]; expT e; logic [31:0] rd; logic er; int lat; int startCycle;
        ops.push_back(mkOp(32'h10, 1'b1, 32'hABCD, 0, 1'b0));
        ops.push_back(mkOp(32'h10, 1'b0, 0, 32'hABCD, 1'b0));
        ops.push_back(mkOp(32'h0C, 1'b1, 32'hFFFF_FFF6, 0, 1'b0));
        ops.push_back(mkOp(32'h0C, 1'b0, 0, 32'h6, 1'b0));
        ops.push_back(mkOp(32'h08, 1'b0, 0, statusWord(1, 0, 1'b0), 1'b0));
        startCycle = cycle;
        foreach (ops[k]) begin
            expQ.push_back(mkExp(ops[k].expData, ops[k].expErr));
            apb_access(ops[k].addr, ops[k].wr, ops[k].wdata, ops[k].hold, rd, er, lat);
            e = expQ.pop_front();
            vectorsApplied++;
            if (rd !== e.data || er !== e.err || lat != 1) begin
                miscompares++;
                $display("[TB] FAIL b2b_op[%0d] @%h: got %h/%b lat %0d, want %h/%b lat 1",
                         k, ops[k].addr, rd, er, lat, e.data, e.err);
            end
        end
        vectorsApplied++;
        if (cycle - startCycle != 15) begin
            miscompares++;
            $display("[TB] FAIL b2b_cycles: got %0d cycles for 5 transfers, want 15", cycle - startCycle);
        end
    endtask

    task automatic test_reset_mid_transfer;
        expT e; logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 3; i++) pulse_rx(8'(8'h31 + i));
        expQ.push_back(mkExp(32'(rxModel.pop_front()), 1'b0));
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04; pwdata = 0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        e = expQ.pop_front();
        vectorsApplied++;
        if (pready !== 1'b1 || prdata !== e.data || pslverr !== e.err) begin
            miscompares++;
            $display("[TB] FAIL rstmid_first: got pready %b %h/%b, want pready 1 %h/%b",
                     pready, prdata, pslverr, e.data, e.err);
        end
        #1 rst = 1'b1;
        #1;
        rxModel.delete(); rxOvr = 1'b0;
        vectorsApplied++;
        if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0 || txValid !== 1'b0 ||
            irq !== 1'b0 || baudDiv !== 16'd868) begin
            miscompares++;
            $display("[TB] FAIL rstmid_async: got pready %b prdata %h err %b txv %b irq %b baud %0d, want 0/0/0/0/0/868",
                     pready, prdata, pslverr, txValid, irq, baudDiv);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.push_back(mkExp(0, 1'b1));
        lat = 0; rd = 'x; er = 1'bx;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (pready) begin
                lat = c; rd = prdata; er = pslverr;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        e = expQ.pop_front();
        vectorsApplied++;
        if (rd !== e.data || er !== e.err || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL rstmid_resume: got %h/%b lat %0d, want %h/%b lat 1",
                     rd, er, lat, e.data, e.err);
        end
        expQ.push_back(mkExp(statusWord(0, 0, 1'b0), 1'b0));
        apb_access(32'h08, 1'b0, 0, 1'b0, rd, er, lat);
        e = expQ.pop_front();
        vectorsApplied++;
        if (rd !== e.data || er !== e.err || lat != 1) begin
            miscompares++;
            $display("[TB] FAIL rstmid_status: got %h/%b lat %0d, want %h/%b lat 1",
                     rd, er, lat, e.data, e.err);
        end
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 0; pwdata = 0;
        txReady = 1'b0; rxData = 0; rxValid = 1'b0;
        test_reset;
        test_baud_div;
        test_tx_fill_drain;
        test_rx_fill_overrun;
        test_hold;
        test_back_to_back;
        test_reset_mid_transfer;
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
